// File: rtl/demux_stream_reg.sv
// demux_stream_reg
// Registered 1-to-N valid/ready stream demultiplexer. Each of the
// N = 2^snum output channels owns a one-entry holding register with its own
// handshake, so a stalled consumer only blocks beats addressed to it.
// A beat is routed to channel sel, or to every channel when i_bcast = 1
// (all-or-nothing: it is accepted only when every channel can take it).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   i        input beat data (width bits)
//   i_valid  input beat valid
//   i_ready  block can accept the current beat (combinational, 0 in reset)
//   sel      destination channel for unicast beats
//   i_bcast  1 = beat goes to all N channels, sel ignored
//   o        flattened channel data, channel c at o[c*width +: width]
//   o_valid  per-channel valid
//   o_ready  per-channel consumer ready
module demux_stream_reg #(
  parameter  int width = 8,
  parameter  int snum  = 4,
  localparam int n     = 1 << snum
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [width-1:0]     i,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [snum-1:0]      sel,
  input  logic                 i_bcast,
  output logic [n*width-1:0]   o,
  output logic [n-1:0]         o_valid,
  input  logic [n-1:0]         o_ready
);

  logic [width-1:0] d [n];
  logic [n-1:0]     v;
  logic [n-1:0]     acc;
  logic [n-1:0]     tgt;
  logic [n-1:0]     load;

  // NOTE: every signal written in a combinational block gets a value on
  // every path (here, first), otherwise synthesis infers a latch.
  always_comb begin
    // A full channel being drained this cycle can take a new beat.
    acc  = ~v | o_ready;
    tgt  = i_bcast ? {n{1'b1}} : ({{(n-1){1'b0}}, 1'b1} << sel);
    // Every targeted channel must be able to accept: acc[sel] for unicast,
    // AND over all channels for broadcast.
    i_ready = ~rst & ((acc & tgt) == tgt);
    load    = tgt & {n{i_valid & i_ready}};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the data registers are reset as well as the valid flags, because
  // o must read zero during and after reset, not whatever was last loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int c = 0; c < n; c++) d[c] <= '0;
    end else begin
      for (int c = 0; c < n; c++) begin
        if (load[c]) begin
          // Load wins over a simultaneous drain: no bubble between beats.
          d[c] <= i;
          v[c] <= 1'b1;
        end else if (o_ready[c]) begin
          // Drain (harmless when already empty); data keeps its last value.
          v[c] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    o = '0;
    for (int c = 0; c < n; c++) o[c*width +: width] = d[c];
  end

  assign o_valid = v;

endmodule

// File: tb/tb_demux_stream_reg.sv
// Self-checking bench for demux_stream_reg: directed scenarios followed by a
// randomized run against a per-channel queue model of the stream behaviour.
module tb_demux_stream_reg;

  localparam int W = 8;
  localparam int S = 4;
  localparam int N = 1 << S;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   i;
  logic           i_valid;
  logic           i_ready;
  logic [S-1:0]   sel;
  logic           i_bcast;
  logic [N*W-1:0] o;
  logic [N-1:0]   o_valid;
  logic [N-1:0]   o_ready;

  int checks = 0;
  int errors = 0;

  // Model: each channel is a FIFO of accepted beats with room for one,
  // plus the last beat it was given (what its data output shows).
  logic [W-1:0] mq   [N][$];
  logic [W-1:0] mlast[N];

  demux_stream_reg #(.width(W), .snum(S)) dut (
    .clk(clk), .rst(rst), .i(i), .i_valid(i_valid), .i_ready(i_ready),
    .sel(sel), .i_bcast(i_bcast), .o(o), .o_valid(o_valid), .o_ready(o_ready)
  );

  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      mlast[c] = '0;
    end
  endfunction

  function automatic logic m_ready();
    logic r;
    r = !rst;
    for (int c = 0; c < N; c++)
      if ((i_bcast || sel == S'(c)) && mq[c].size() != 0 && !o_ready[c]) r = 1'b0;
    return r;
  endfunction

  function automatic logic [N-1:0] m_valid();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = (mq[c].size() != 0);
    return r;
  endfunction

  function automatic logic [N*W-1:0] m_o();
    logic [N*W-1:0] r;
    for (int c = 0; c < N; c++) r[c*W +: W] = mlast[c];
    return r;
  endfunction

  function automatic logic [W-1:0] ch(input int c);
    return o[c*W +: W];
  endfunction

  // Advance one clock: decide acceptance from the inputs held across the
  // edge, then apply drains and loads to the model. Returns at edge + 1.
  task automatic tick();
    logic         acc;
    logic [W-1:0] beat;
    logic [S-1:0] s;
    logic         bc;
    logic [N-1:0] orq;
    acc  = i_valid && m_ready();
    beat = i;
    s    = sel;
    bc   = i_bcast;
    orq  = o_ready;
    @(posedge clk);
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        if (mq[c].size() != 0 && orq[c]) void'(mq[c].pop_front());
        if (acc && (bc || s == S'(c))) begin
          mq[c].push_back(beat);
          mlast[c] = beat;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i = 8'h5A; i_valid = 1'b1; sel = 4'd3; i_bcast = 1'b0; o_ready = '1;
    m_clear();
    #1;
    checks++; if (o !== '0) begin errors++; $display("FAIL reset_o got %h exp 0", o); end
    checks++; if (o_valid !== '0) begin errors++; $display("FAIL reset_o_valid got %h exp 0", o_valid); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL reset_i_ready got %b exp 0", i_ready); end
    tick(); tick();
    checks++; if (o_valid !== '0) begin errors++; $display("FAIL reset_hold_o_valid got %h exp 0", o_valid); end
    rst = 1'b0; i_valid = 1'b0;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_release_i_ready got %b exp 1", i_ready); end
    tick();
  endtask

  task automatic test_unicast_sweep();
    o_ready = '1; i_bcast = 1'b0;
    for (int k = 0; k < N; k++) begin
      i = 8'hA0 + W'(k); sel = S'(k); i_valid = 1'b1;
      #1;
      checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL sweep_i_ready[%0d] got %b exp 1", k, i_ready); end
      tick();
      checks++; if (o_valid !== (N'(1) << k)) begin errors++; $display("FAIL sweep_o_valid[%0d] got %h exp %h", k, o_valid, N'(1) << k); end
      checks++; if (ch(k) !== 8'hA0 + W'(k)) begin errors++; $display("FAIL sweep_o[%0d] got %h exp %h", k, ch(k), 8'hA0 + W'(k)); end
    end
    i_valid = 1'b0;
    tick();
    checks++; if (o_valid !== '0) begin errors++; $display("FAIL sweep_end_o_valid got %h exp 0", o_valid); end
  endtask

  task automatic test_backpressure();
    o_ready = '1; o_ready[3] = 1'b0; i_bcast = 1'b0;
    i = 8'hB0; sel = 4'd3; i_valid = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b exp 1", i_ready); end
    tick();
    i = 8'hB1;
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_second_ready got %b exp 0", i_ready); end
    tick();
    checks++; if (ch(3) !== 8'hB0 || o_valid[3] !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%b exp b0/1", ch(3), o_valid[3]); end
    o_ready[3] = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_reload_ready got %b exp 1", i_ready); end
    tick();
    checks++; if (ch(3) !== 8'hB1 || o_valid[3] !== 1'b1) begin errors++; $display("FAIL bp_reload got %h/%b exp b1/1", ch(3), o_valid[3]); end
    // Leave channel 3 stalled full with B1 for the isolation test.
    i_valid = 1'b0; o_ready[3] = 1'b0;
    tick();
  endtask

  task automatic test_isolation();
    i = 8'hC5; sel = 4'd5; i_valid = 1'b1; i_bcast = 1'b0;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL iso_ready got %b exp 1", i_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (ch(5) !== 8'hC5 || o_valid[5] !== 1'b1) begin errors++; $display("FAIL iso_ch5 got %h/%b exp c5/1", ch(5), o_valid[5]); end
    checks++; if (ch(3) !== 8'hB1 || o_valid[3] !== 1'b1) begin errors++; $display("FAIL iso_ch3 got %h/%b exp b1/1", ch(3), o_valid[3]); end
    tick();
    checks++; if (o_valid !== 16'h0008) begin errors++; $display("FAIL iso_after got %h exp 0008", o_valid); end
  endtask

  task automatic test_broadcast();
    o_ready = '1; i_bcast = 1'b1; sel = 4'd0; i = 8'hD0; i_valid = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bc_ready got %b exp 1", i_ready); end
    tick();
    checks++; if (o_valid !== '1) begin errors++; $display("FAIL bc_o_valid got %h exp ffff", o_valid); end
    checks++; if (o !== {N{8'hD0}}) begin errors++; $display("FAIL bc_o got %h exp all d0", o); end
    o_ready[7] = 1'b0; i = 8'hD1;
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL bc_blocked_ready got %b exp 0", i_ready); end
    tick();
    checks++; if (o_valid !== 16'h0080) begin errors++; $display("FAIL bc_blocked_o_valid got %h exp 0080", o_valid); end
    checks++; if (o !== {N{8'hD0}}) begin errors++; $display("FAIL bc_blocked_o got %h exp all d0", o); end
    i_valid = 1'b0; i_bcast = 1'b0; o_ready = '1;
    tick();
    checks++; if (o_valid !== '0) begin errors++; $display("FAIL bc_drain got %h exp 0", o_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] vals [3];
    vals[0] = 8'hE0; vals[1] = 8'hE1; vals[2] = 8'hE2;
    o_ready = '1; i_bcast = 1'b0; sel = 4'd9;
    for (int k = 0; k < 3; k++) begin
      i = vals[k]; i_valid = 1'b1;
      #1;
      checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, i_ready); end
      tick();
      checks++; if (o_valid[9] !== 1'b1 || ch(9) !== vals[k]) begin errors++; $display("FAIL b2b_o[%0d] got %h/%b exp %h/1", k, ch(9), o_valid[9], vals[k]); end
    end
    i_valid = 1'b0;
    tick();
    checks++; if (o_valid[9] !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", o_valid[9]); end
  endtask

  task automatic test_reset_mid();
    o_ready = '1; o_ready[2] = 1'b0; o_ready[9] = 1'b0; i_bcast = 1'b0;
    i = 8'hF2; sel = 4'd2; i_valid = 1'b1; tick();
    i = 8'hF9; sel = 4'd9; tick();
    checks++; if (o_valid !== 16'h0204) begin errors++; $display("FAIL mid_full got %h exp 0204", o_valid); end
    #2 rst = 1'b1;
    m_clear();
    #1;
    checks++; if (o !== '0 || o_valid !== '0) begin errors++; $display("FAIL mid_rst_out got %h/%h exp 0/0", o, o_valid); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", i_ready); end
    tick();
    rst = 1'b0; o_ready = '1; i = 8'hA5; sel = 4'd2; i_valid = 1'b1;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", i_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_valid !== 16'h0004 || ch(2) !== 8'hA5) begin errors++; $display("FAIL mid_after got %h/%h exp 0004/a5", o_valid, ch(2)); end
    tick();
  endtask

  task automatic test_random();
    logic stall;
    stall = 1'b0;
    for (int k = 0; k < 600; k++) begin
      // Producer holds its beat while stalled.
      if (!stall) begin
        i       = W'($urandom);
        sel     = S'($urandom);
        i_bcast = ($urandom_range(7) == 0);
        i_valid = ($urandom_range(3) != 0);
      end
      for (int c = 0; c < N; c++) o_ready[c] = ($urandom_range(2) != 0);
      #1;
      checks++; if (i_ready !== m_ready()) begin errors++; $display("FAIL rnd_i_ready[%0d] got %b exp %b", k, i_ready, m_ready()); end
      checks++; if (o_valid !== m_valid()) begin errors++; $display("FAIL rnd_o_valid[%0d] got %h exp %h", k, o_valid, m_valid()); end
      checks++; if (o !== m_o()) begin errors++; $display("FAIL rnd_o[%0d] got %h exp %h", k, o, m_o()); end
      stall = i_valid && !m_ready();
      tick();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unicast_sweep();
    test_backpressure();
    test_isolation();
    test_broadcast();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
